// File: rtl/led_sequence_player.sv
// LED sequence player: a small FIFO of {pattern, ticks} entries, each shown on
// the LED bank for a programmed number of prescaled ticks. Supports one-shot
// playback, looped playback (completed entries re-appended) and abort.
module led_sequence_player #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned TICK_HZ      = 1_000,
  parameter int unsigned DEPTH        = 4,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_pattern,
  input  logic [15:0]              cmd_ticks,
  input  logic                     loop_en,
  input  logic                     abort,
  output logic [7:0]               leds,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW       = $clog2(DEPTH);

  localparam logic [PW-1:0] PrescMax  = PW'(TICK_DIV - 1);
  localparam logic [AW:0]   LevelFull = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

  state_e          state_q;
  logic [7:0]      leds_q;
  logic [PW-1:0]   presc_q;
  logic [15:0]     tick_cnt_q;
  logic [7:0]      cur_pattern_q;
  logic [15:0]     cur_ticks_q;
  logic            replay_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     level_q;
  logic [AW:0]     level_d;
  logic [23:0]     mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            reappend;
  logic            replay;
  logic            wr_en;
  logic [23:0]     wr_data;
  logic [23:0]     head;
  logic            tick_wrap;
  logic            entry_end;
  logic [15:0]     cur_len;

  assign cmd_ready = (level_q != LevelFull) & ~loop_en & ~abort;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  assign cur_len   = (cur_ticks_q == 16'd0) ? 16'd1 : cur_ticks_q;
  assign tick_wrap = (state_q == StPlay) && (presc_q == PrescMax);
  assign entry_end = tick_wrap && ((tick_cnt_q + 16'd1) == cur_len);

  // A lone looping entry is replayed from cur_* instead of going through the
  // FIFO, so level stays 0. A re-append into a full FIFO (host filled it
  // before loop_en rose) is dropped: there is no slot for it.
  assign replay    = entry_end && loop_en && (level_q == '0);
  assign reappend  = entry_end && loop_en && (level_q != '0) && (level_q != LevelFull);
  assign pop       = (state_q == StLoad) && !replay_q;

  // Host pushes require !loop_en and re-appends require loop_en: never both.
  assign wr_en     = (push | reappend) & ~abort;
  assign wr_data   = push ? {cmd_pattern, cmd_ticks} : {cur_pattern_q, cur_ticks_q};

  assign leds      = leds_q;
  assign busy      = (state_q != StIdle);
  assign level     = level_q;

  // Next FIFO occupancy from this cycle's write and pop.
  always_comb begin
    level_d = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + (AW + 1)'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - (AW + 1)'(1);
    end
  end

  // FIFO storage; flushing only resets pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Playback FSM, prescaler, tick counter and FIFO pointers; abort wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      leds_q        <= IDLE_PATTERN;
      presc_q       <= '0;
      tick_cnt_q    <= '0;
      cur_pattern_q <= '0;
      cur_ticks_q   <= '0;
      replay_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
    end else if (abort) begin
      state_q    <= StIdle;
      leds_q     <= IDLE_PATTERN;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      replay_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      level_q <= level_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (level_q != '0) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (!replay_q) begin
            cur_pattern_q <= head[23:16];
            cur_ticks_q   <= head[15:0];
            leds_q        <= head[23:16];
          end
          presc_q    <= '0;
          tick_cnt_q <= '0;
          replay_q   <= 1'b0;
          state_q    <= StPlay;
        end
        StPlay: begin
          if (tick_wrap) begin
            presc_q <= '0;
            if (entry_end) begin
              tick_cnt_q <= '0;
              replay_q   <= replay;
              if (level_d != '0 || replay) begin
                state_q <= StLoad;
              end else begin
                state_q <= StIdle;
                leds_q  <= IDLE_PATTERN;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 16'd1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          leds_q  <= IDLE_PATTERN;
        end
      endcase
    end
  end

endmodule
